// File: rtl/divide_n_clkgen_if.sv
// Divide-by-N clock generator interface: run request, divisor load and status outputs.
interface divide_n_clkgen_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [WIDTH-1:0] div;
   logic             div_load;
   logic             clk_out;
   logic             tc;
   logic             busy;
   logic             div_ack;
   logic             div_err;

   modport master (
      output en, div, div_load,
      input  clk_out, tc, busy, div_ack, div_err
   );

   modport slave (
      input  en, div, div_load,
      output clk_out, tc, busy, div_ack, div_err
   );
endinterface

// File: rtl/divide_n_clkgen.sv
// Programmable divide-by-N clock generator with glitch-free stop/start and
// divisor changes applied only at period boundaries.
// Optional feature macro: DIVN_ODD_DUTY50_EN (negedge term for 50% duty on odd N).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | stopped, cnt held at 0, clk_out low, divisor loads apply at once
// S_RUN     | counting 0..N-1, en high
// S_STOPPING| en seen low, finishing the current period, stops at TC
module divide_n_clkgen #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input logic               clk,
   input logic               reset,
   divide_n_clkgen_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_STOPPING = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic             clk_pos_q, clk_pos_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             load_ok;
   logic [WIDTH-1:0] h_d;

   // State, counter, divisor and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         n_q       <= WIDTH'(DEFAULT_DIV);
         pend_q    <= '0;
         pend_v_q  <= 1'b0;
         clk_pos_q <= 1'b0;
         tc_q      <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         pend_q    <= pend_d;
         pend_v_q  <= pend_v_d;
         clk_pos_q <= clk_pos_d;
         tc_q      <= tc_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   // Next state, counter, divisor swap at the wrap, and next output values.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      ack_d    = 1'b0;
      load_ok  = bus.div_load && (bus.div >= WIDTH'(2));
      err_d    = bus.div_load && (bus.div < WIDTH'(2));

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (load_ok) begin
               n_d   = bus.div;
               ack_d = 1'b1;
            end
            if (bus.en) state_d = S_RUN;
         end
         default: begin
            // tc_q is high exactly in the cnt==N-1 cycle, so it marks the wrap.
            if (tc_q) begin
               cnt_d = '0;
               if (load_ok) begin
                  n_d      = bus.div;
                  ack_d    = 1'b1;
                  pend_v_d = 1'b0;
               end else if (pend_v_q) begin
                  n_d      = pend_q;
                  ack_d    = 1'b1;
                  pend_v_d = 1'b0;
               end
               // en low at the wrap ends the run; the finished period was complete.
               state_d = bus.en ? S_RUN : S_IDLE;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
               if (load_ok) begin
                  pend_d   = bus.div;
                  pend_v_d = 1'b1;
               end
               state_d = bus.en ? S_RUN : S_STOPPING;
            end
         end
      endcase

      h_d       = (n_d >> 1) + {{(WIDTH-1){1'b0}}, n_d[0]};
      busy_d    = (state_d != S_IDLE);
      clk_pos_d = busy_d && (cnt_d < h_d);
      tc_d      = busy_d && (cnt_d == n_d - WIDTH'(1));
   end

`ifdef DIVN_ODD_DUTY50_EN
   logic neg_q;
   logic odd_q;

   // Half-cycle delayed copy of the posedge term; ANDing trims half a cycle off the high phase.
   always_ff @(negedge clk) begin
      if (!reset) neg_q <= 1'b0;
      else        neg_q <= clk_pos_q;
   end

   // Tracks whether the divisor governing the current period is odd.
   always_ff @(posedge clk) begin
      if (!reset) odd_q <= 1'(DEFAULT_DIV % 2);
      else        odd_q <= n_d[0];
   end

   assign bus.clk_out = odd_q ? (clk_pos_q & neg_q) : clk_pos_q;
`else
   assign bus.clk_out = clk_pos_q;
`endif

   assign bus.tc      = tc_q;
   assign bus.busy    = busy_q;
   assign bus.div_ack = ack_q;
   assign bus.div_err = err_q;

endmodule

// File: tb/tb_divide_n_clkgen.sv
// Bench for divide_n_clkgen: directed scenarios plus randomized traffic,
// checked against a period-level reference model.
module tb_divide_n_clkgen;
   localparam int WIDTH = 8;
   localparam int DEF   = 4;

   logic clk;
   logic reset;

   divide_n_clkgen_if #(.WIDTH(WIDTH)) bus ();

   divide_n_clkgen #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: running flag, position in period, active and pending divisor.
   bit m_act;
   int m_p;
   int m_n;
   int m_pend;
   bit m_pv;
   bit e_ack;
   bit e_err;

   function automatic logic [4:0] exp_vec();
      bit c, t;
      c = m_act && (m_p < (m_n + 1) / 2);
      t = m_act && (m_p == m_n - 1);
      return {c, t, m_act, e_ack, e_err};
   endfunction

   function automatic logic [4:0] obs_vec();
      return {bus.clk_out, bus.tc, bus.busy, bus.div_ack, bus.div_err};
   endfunction

   // Advance one source cycle, update the model from the sampled inputs, settle.
   task automatic step();
      bit ok;
      int d;
      @(posedge clk);
      e_ack = 1'b0;
      e_err = 1'b0;
      if (!reset) begin
         m_act = 1'b0; m_p = 0; m_n = DEF; m_pv = 1'b0;
      end else begin
         d     = int'(bus.div);
         ok    = bus.div_load && (d >= 2);
         e_err = bus.div_load && (d < 2);
         if (!m_act) begin
            if (ok) begin m_n = d; e_ack = 1'b1; end
            if (bus.en) begin m_act = 1'b1; m_p = 0; end
         end else if (m_p == m_n - 1) begin
            m_p = 0;
            if (ok) begin m_n = d; e_ack = 1'b1; m_pv = 1'b0; end
            else if (m_pv) begin m_n = m_pend; e_ack = 1'b1; m_pv = 1'b0; end
            if (!bus.en) m_act = 1'b0;
         end else begin
            m_p++;
            if (ok) begin m_pend = d; m_pv = 1'b1; end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.en = 1'b1; bus.div_load = 1'b1; bus.div = 8'd9;
      step(); step();
      n_tests++;
      if (obs_vec() !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b exp=%b", obs_vec(), 5'b0);
      end
      bus.div_load = 1'b0;
      bus.en       = 1'b0;
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_hold got=%b exp=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_basic();
      logic [3:0] pat;
      pat = 4'b1100;
      reset  = 1'b1;
      bus.en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         n_tests++;
         if (obs_vec() !== exp_vec() || bus.clk_out !== pat[3 - (i % 4)] ||
             bus.tc !== ((i % 4) == 3) || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_n4 cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_div_change();
      for (int i = 0; i < 8 && m_p != 1; i++) step();
      bus.div = 8'd3; bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
      n_tests++;
      if (obs_vec() !== exp_vec() || bus.div_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL div_change_load got=%b exp=%b", obs_vec(), exp_vec());
      end
      for (int i = 0; i < 10; i++) begin
         step();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL div_change cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_div_err();
      bus.div = 8'd4; bus.div_load = 1'b1;
      step();
      bus.div = 8'd1;
      step();
      bus.div = 8'd0;
      for (int i = 0; i < 10; i++) begin
         step();
         bus.div_load = 1'b0;
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL div_err cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_stop();
      bus.div = 8'd6; bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
      for (int i = 0; i < 20 && !(m_n == 6 && m_p == 1); i++) step();
      bus.en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL stop cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
      n_tests++;
      if (bus.busy !== 1'b0 || bus.clk_out !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_idle got busy=%b clk_out=%b exp busy=0 clk_out=0", bus.busy, bus.clk_out);
      end
      bus.en = 1'b1;
      step();
      n_tests++;
      if (bus.clk_out !== 1'b1 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart got clk_out=%b busy=%b exp 1 1", bus.clk_out, bus.busy);
      end
   endtask

   task automatic test_tc_load();
      for (int i = 0; i < 10 && m_p != m_n - 1; i++) step();
      bus.div = 8'd5; bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
      for (int i = 0; i < 11; i++) begin
         n_tests++;
         if (obs_vec() !== exp_vec() || (i == 0 && bus.div_ack !== 1'b1)) begin
            n_fail++;
            $display("FAIL tc_load cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10 && m_p != 1; i++) step();
      bus.div = 8'd7; bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
      reset = 1'b0;
      step();
      n_tests++;
      if (obs_vec() !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_mid got=%b exp=%b", obs_vec(), 5'b0);
      end
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_tests++;
         if (obs_vec() !== exp_vec() || bus.div_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset        = ($urandom_range(0, 299) != 0);
         bus.en       = ($urandom_range(0, 9) < 8);
         bus.div_load = ($urandom_range(0, 7) == 0);
         bus.div      = 8'($urandom_range(0, 12));
         step();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      reset = 1'b0; bus.en = 1'b0; bus.div = '0; bus.div_load = 1'b0;
      m_act = 1'b0; m_p = 0; m_n = DEF; m_pend = 0; m_pv = 1'b0;
      e_ack = 1'b0; e_err = 1'b0;
      test_reset();
      test_basic();
      test_div_change();
      test_div_err();
      test_stop();
      test_tc_load();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
